// File: rtl/cam_pkg.sv
// Shared constants, types and helpers for the CAM match-line encoder.
package cam_pkg;

  localparam int ENTRIES_DEF = 32;
  localparam int IDX_W_DEF   = $clog2(ENTRIES_DEF);
  localparam int CNT_W_DEF   = $clog2(ENTRIES_DEF) + 1;

  // Widest match vector the popcount helper supports; narrower vectors are zero-extended.
  localparam int POP_MAX_W   = 1024;

  typedef logic [ENTRIES_DEF-1:0] match_vec_t;
  typedef logic [IDX_W_DEF-1:0]   cam_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } enc_state_e;

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/cam_lsb_prio_enc.sv
// Lowest-set-bit priority encoder: index of the lowest set bit, any-set flag,
// and the input with that bit cleared.
module cam_lsb_prio_enc #(
  parameter int WIDTH = 32,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic [WIDTH-1:0] rest
);

  // Scanning from the top down lets the lowest set bit win the last assignment.
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any  = |vec;
  assign rest = vec & (vec - WIDTH'(1));

endmodule

// File: rtl/cam_match_encoder.sv
// Converts a captured CAM match vector into its matching entry indices,
// emitted in ascending order, one per output handshake.
module cam_match_encoder
  import cam_pkg::*;
#(
  parameter int ENTRIES = ENTRIES_DEF,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int CNT_W   = $clog2(ENTRIES) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ENTRIES-1:0] match_i,
  input  logic               match_valid_i,
  output logic               match_ready_o,
  input  logic               flush_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               idx_valid_o,
  input  logic               idx_ready_i,
  output logic               miss_o,
  output logic               last_o,
  output logic [CNT_W-1:0]   count_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // A producer holding valid keeps its payload stable until that edge; ready may
  // depend on state only, never on the partner's valid.

  enc_state_e         state_q, state_n;
  logic [ENTRIES-1:0] pending_q, pending_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic               valid_q, valid_n;
  logic               miss_q, miss_n;
  logic               last_q, last_n;
  logic [CNT_W-1:0]   count_q, count_n;

  logic [ENTRIES-1:0] enc_vec;
  logic [IDX_W-1:0]   enc_idx;
  logic               enc_any;
  logic [ENTRIES-1:0] enc_rest;
  logic               out_accept;

  // One encoder serves both the fresh vector and the remaining hits.
  assign enc_vec = (state_q == IDLE) ? match_i : pending_q;

  cam_lsb_prio_enc #(
    .WIDTH (ENTRIES),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .vec  (enc_vec),
    .idx  (enc_idx),
    .any  (enc_any),
    .rest (enc_rest)
  );

  assign out_accept = valid_q && idx_ready_i;

  always_comb begin
    state_n   = state_q;
    pending_n = pending_q;
    idx_n     = idx_q;
    valid_n   = valid_q;
    miss_n    = miss_q;
    last_n    = last_q;
    count_n   = count_q;

    if (flush_i) begin
      state_n   = IDLE;
      valid_n   = 1'b0;
      pending_n = '0;
      miss_n    = 1'b0;
      last_n    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (match_valid_i) begin
            state_n = EMIT;
            valid_n = 1'b1;
            count_n = CNT_W'(popcount(POP_MAX_W'(match_i)));
            if (!enc_any) begin
              miss_n    = 1'b1;
              last_n    = 1'b1;
              idx_n     = '0;
              pending_n = '0;
            end else begin
              miss_n    = 1'b0;
              idx_n     = enc_idx;
              pending_n = enc_rest;
              last_n    = (enc_rest == '0);
            end
          end
        end
        EMIT: begin
          if (out_accept) begin
            if (last_q) begin
              state_n = IDLE;
              valid_n = 1'b0;
              miss_n  = 1'b0;
              last_n  = 1'b0;
            end else begin
              idx_n     = enc_idx;
              pending_n = enc_rest;
              last_n    = (enc_rest == '0);
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      miss_q    <= 1'b0;
      last_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_n;
      pending_q <= pending_n;
      idx_q     <= idx_n;
      valid_q   <= valid_n;
      miss_q    <= miss_n;
      last_q    <= last_n;
      count_q   <= count_n;
    end
  end

  assign match_ready_o = (state_q == IDLE);
  assign idx_o         = idx_q;
  assign idx_valid_o   = valid_q;
  assign miss_o        = miss_q;
  assign last_o        = last_q;
  assign count_o       = count_q;

  // A stalled beat must present the same payload on the next cycle.
  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (valid_q && !idx_ready_i && !flush_i) |=> (valid_q && $stable(idx_q) && $stable(last_q)
                                               && $stable(miss_q) && $stable(count_q)));

  a_valid_only_in_emit: assert property (@(posedge clk) disable iff (rst)
    valid_q |-> (state_q == EMIT));

endmodule

// File: tb/tb_cam_match_encoder.sv
// Self-checking bench for cam_match_encoder: directed scenarios plus random
// lookups against an ascending-index reference list.
module tb_cam_match_encoder;

  localparam int ENTRIES = 32;
  localparam int IDX_W   = 5;
  localparam int CNT_W   = 6;

  logic               clk;
  logic               rst;
  logic [ENTRIES-1:0] match_i;
  logic               match_valid_i;
  logic               match_ready_o;
  logic               flush_i;
  logic [IDX_W-1:0]   idx_o;
  logic               idx_valid_o;
  logic               idx_ready_i;
  logic               miss_o;
  logic               last_o;
  logic [CNT_W-1:0]   count_o;

  int n_cmp;
  int n_err;

  logic [IDX_W-1:0] exp_q[$];

  cam_match_encoder #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .match_i       (match_i),
    .match_valid_i (match_valid_i),
    .match_ready_o (match_ready_o),
    .flush_i       (flush_i),
    .idx_o         (idx_o),
    .idx_valid_o   (idx_valid_o),
    .idx_ready_i   (idx_ready_i),
    .miss_o        (miss_o),
    .last_o        (last_o),
    .count_o       (count_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference model: every set bit position, ascending; a miss is one beat at index 0
  task automatic build_expected(input logic [ENTRIES-1:0] vec, output int cnt, output logic miss);
    exp_q.delete();
    cnt = 0;
    for (int k = 0; k < ENTRIES; k++) begin
      if (vec[k]) begin
        exp_q.push_back(IDX_W'(k));
        cnt++;
      end
    end
    miss = (cnt == 0);
    if (miss) exp_q.push_back('0);
  endtask

  // full lookup with random output backpressure, checked beat by beat
  task automatic do_lookup(input logic [ENTRIES-1:0] vec, input int rdy_pct, input string name);
    int cnt;
    logic miss;
    int cycles;
    logic rdy;
    build_expected(vec, cnt, miss);
    n_cmp++;
    if (match_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL %s ready_before: got %b want 1", name, match_ready_o);
    end
    match_i = vec;
    match_valid_i = 1'b1;
    step();
    match_valid_i = 1'b0;
    match_i = $urandom;
    cycles = 0;
    while (exp_q.size() > 0 && cycles < 400) begin
      rdy = ($urandom_range(99) < rdy_pct);
      idx_ready_i = rdy;
      n_cmp++;
      if (idx_valid_o !== 1'b1 || idx_o !== exp_q[0] || last_o !== (exp_q.size() == 1)
          || miss_o !== miss || count_o !== CNT_W'(cnt) || match_ready_o !== 1'b0) begin
        n_err++;
        $display("FAIL %s beat: got v=%b idx=%0d last=%b miss=%b cnt=%0d rdy=%b want v=1 idx=%0d last=%b miss=%b cnt=%0d rdy=0",
                 name, idx_valid_o, idx_o, last_o, miss_o, count_o, match_ready_o,
                 exp_q[0], (exp_q.size() == 1), miss, cnt);
      end
      step();
      if (rdy) void'(exp_q.pop_front());
      cycles++;
    end
    idx_ready_i = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s timeout: got %0d beats left want 0", name, exp_q.size());
    end
    n_cmp++;
    if (idx_valid_o !== 1'b0 || match_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL %s end_idle: got v=%b rdy=%b want v=0 rdy=1", name, idx_valid_o, match_ready_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    match_i = '0;
    match_valid_i = 1'b0;
    flush_i = 1'b0;
    idx_ready_i = 1'b0;
    #1 rst = 1'b1;
    #2;
    n_cmp++;
    if (idx_valid_o !== 1'b0 || idx_o !== '0 || miss_o !== 1'b0 || last_o !== 1'b0
        || count_o !== '0 || match_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset_values: got v=%b idx=%0d miss=%b last=%b cnt=%0d rdy=%b want 0,0,0,0,0,1",
               idx_valid_o, idx_o, miss_o, last_o, count_o, match_ready_o);
    end
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_and_miss();
    do_lookup(32'h0000_0400, 100, "single_hit");
    do_lookup(32'h0000_0000, 100, "miss");
    do_lookup(32'h8000_0011, 100, "multi_hit");
    do_lookup(32'h8000_0000, 100, "top_bit");
  endtask

  task automatic test_backpressure();
    match_i = 32'h0000_0006;
    match_valid_i = 1'b1;
    idx_ready_i = 1'b0;
    step();
    match_valid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (idx_valid_o !== 1'b1 || idx_o !== 5'd1 || last_o !== 1'b0 || match_ready_o !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold: got v=%b idx=%0d last=%b rdy=%b want v=1 idx=1 last=0 rdy=0",
                 idx_valid_o, idx_o, last_o, match_ready_o);
      end
      step();
    end
    idx_ready_i = 1'b1;
    n_cmp++;
    if (idx_o !== 5'd1 || idx_valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL bp_first: got idx=%0d v=%b want idx=1 v=1", idx_o, idx_valid_o);
    end
    step();
    n_cmp++;
    if (idx_o !== 5'd2 || idx_valid_o !== 1'b1 || last_o !== 1'b1 || count_o !== 6'd2) begin
      n_err++;
      $display("FAIL bp_second: got idx=%0d v=%b last=%b cnt=%0d want idx=2 v=1 last=1 cnt=2",
               idx_o, idx_valid_o, last_o, count_o);
    end
    step();
    idx_ready_i = 1'b0;
    n_cmp++;
    if (idx_valid_o !== 1'b0 || match_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL bp_end: got v=%b rdy=%b want v=0 rdy=1", idx_valid_o, match_ready_o);
    end
  endtask

  task automatic test_flush();
    match_i = 32'hFFFF_FFFF;
    match_valid_i = 1'b1;
    idx_ready_i = 1'b1;
    step();
    match_valid_i = 1'b0;
    step();
    step();
    n_cmp++;
    if (idx_o !== 5'd2 || idx_valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL flush_pre: got idx=%0d v=%b want idx=2 v=1", idx_o, idx_valid_o);
    end
    flush_i = 1'b1;
    step();
    // flush in IDLE must also block a simultaneous capture
    match_valid_i = 1'b1;
    n_cmp++;
    if (idx_valid_o !== 1'b0 || match_ready_o !== 1'b1 || last_o !== 1'b0 || miss_o !== 1'b0) begin
      n_err++;
      $display("FAIL flush_idle: got v=%b rdy=%b last=%b miss=%b want 0,1,0,0",
               idx_valid_o, match_ready_o, last_o, miss_o);
    end
    step();
    flush_i = 1'b0;
    match_valid_i = 1'b0;
    n_cmp++;
    if (idx_valid_o !== 1'b0 || match_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL flush_no_capture: got v=%b rdy=%b want v=0 rdy=1", idx_valid_o, match_ready_o);
    end
    idx_ready_i = 1'b0;
    do_lookup(32'h0000_0001, 100, "after_flush");
  endtask

  task automatic test_reset_mid();
    match_i = 32'hFFFF_FFFF;
    match_valid_i = 1'b1;
    idx_ready_i = 1'b1;
    step();
    match_valid_i = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (idx_valid_o !== 1'b0 || idx_o !== '0 || count_o !== '0 || last_o !== 1'b0
        || match_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid: got v=%b idx=%0d cnt=%0d last=%b rdy=%b want 0,0,0,0,1",
               idx_valid_o, idx_o, count_o, last_o, match_ready_o);
    end
    step();
    rst = 1'b0;
    idx_ready_i = 1'b0;
    step();
    do_lookup(32'h0000_0030, 100, "after_reset");
  endtask

  task automatic test_exhaustive();
    logic [ENTRIES-1:0] v;
    for (int b = 0; b < ENTRIES; b++) begin
      v = '0;
      v[b] = 1'b1;
      do_lookup(v, 100, "one_hot");
    end
    do_lookup(32'hFFFF_FFFF, 100, "all_ones");
  endtask

  task automatic test_random();
    logic [ENTRIES-1:0] v;
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(2))
        0: v = $urandom & $urandom & $urandom;
        1: v = $urandom;
        default: v = $urandom | $urandom;
      endcase
      do_lookup(v, 60, "random");
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single_and_miss();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_exhaustive();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
